// File: rtl/apb_master_bridge.sv
// APB initiator: turns single-outstanding core load/store requests into SETUP/ACCESS transfers.
// Optional ACCESS timeout is compiled in with `define APB_BRIDGE_TIMEOUT_EN.
module apb_master_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int APB_DATA_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_wr,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic [APB_DATA_WIDTH-1:0] req_wdata,
   output logic                      resp_valid,
   output logic [APB_DATA_WIDTH-1:0] resp_rdata,
   output logic                      resp_err,
   output logic                      apb_psel,
   output logic                      apb_enab,
   output logic                      apb_rw,
   output logic [ADDR_WIDTH-1:0]     apb_addr,
   output logic [APB_DATA_WIDTH-1:0] apb_datai,
   input  logic [APB_DATA_WIDTH-1:0] apb_datao,
   input  logic                      apb_ack
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic                      psel_q, psel_d;
   logic                      enab_q, enab_d;
   logic                      rw_q, rw_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                      resp_valid_q, resp_valid_d;
   logic [APB_DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic                      resp_err_q, resp_err_d;
   logic                      timeout_s;

`ifdef APB_BRIDGE_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Count ACCESS cycles without ack; cleared while in SETUP so each ACCESS starts at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == SETUP) begin
         cnt_d = '0;
      end else if ((state_q == ACCESS) && !apb_ack) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Wait-cycle counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The edge that would bring the count to TIMEOUT_CYCLES aborts, unless ack arrives on it.
   assign timeout_s = (state_q == ACCESS) && !apb_ack && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
   // Without the timeout the parameter has no effect and ACCESS waits indefinitely.
   assign timeout_s = (TIMEOUT_CYCLES < 1) & 1'b0;
`endif

   // Next-state, request capture and response generation.
   always_comb begin
      state_d      = state_q;
      rw_d         = rw_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = SETUP;
               rw_d    = req_wr;
               addr_d  = req_addr;
               wdata_d = req_wdata;
            end else begin
               state_d = IDLE;
            end
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            if (apb_ack) begin
               state_d      = IDLE;
               resp_valid_d = 1'b1;
               resp_rdata_d = rw_q ? {APB_DATA_WIDTH{1'b0}} : apb_datao;
            end else if (timeout_s) begin
               state_d      = IDLE;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               resp_rdata_d = {APB_DATA_WIDTH{1'b0}};
            end else begin
               state_d = ACCESS;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      psel_d = (state_d != IDLE);
      enab_d = (state_d == ACCESS);
   end

   // State, APB and response registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         psel_q       <= 1'b0;
         enab_q       <= 1'b0;
         rw_q         <= 1'b0;
         addr_q       <= {ADDR_WIDTH{1'b0}};
         wdata_q      <= {APB_DATA_WIDTH{1'b0}};
         resp_valid_q <= 1'b0;
         resp_rdata_q <= {APB_DATA_WIDTH{1'b0}};
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         psel_q       <= psel_d;
         enab_q       <= enab_d;
         rw_q         <= rw_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign apb_psel   = psel_q;
   assign apb_enab   = enab_q;
   assign apb_rw     = rw_q;
   assign apb_addr   = addr_q;
   assign apb_datai  = wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB initiator that converts single-outstanding core load/store requests into the APB transfers consumed by the APB address-decode mux and its slaves. Each accepted request becomes one SETUP phase and one or more ACCESS phases, ending when the selected slave asserts ack. The block sits between the CPU data-bus splitter and the mux's `apb_*_cpu` port group. Read data and completion status return to the core as a one-cycle response pulse.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width; must be 32 to match the decode mux.
- `APB_DATA_WIDTH`, 32, data width.
- `TIMEOUT_CYCLES`, 256, maximum ACCESS cycles before abort; only used with the timeout feature; must be ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `req_valid`  in  1  core request valid.
- `req_ready`  out  1  bridge can accept a request.
- `req_wr`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  byte address.
- `req_wdata`  in  APB_DATA_WIDTH  write data.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  APB_DATA_WIDTH  read data; valid with `resp_valid` for reads.
- `resp_err`  out  1  transfer aborted by timeout; valid with `resp_valid`.
- `apb_psel`  out  1  APB select.
- `apb_enab`  out  1  APB enable (ACCESS phase).
- `apb_rw`  out  1  1 = write.
- `apb_addr`  out  ADDR_WIDTH  APB address.
- `apb_datai`  out  APB_DATA_WIDTH  write data to the slave side.
- `apb_datao`  in  APB_DATA_WIDTH  read data from the mux.
- `apb_ack`  in  1  transfer complete; the mux returns 1 for unmapped addresses.

## Operation
- States: IDLE, SETUP, ACCESS.
- `req_ready` = (state == IDLE); combinational from the state register.
- IDLE: on `req_valid && req_ready`, register `req_wr`/`req_addr`/`req_wdata` into the `apb_rw`/`apb_addr`/`apb_datai` registers; go to SETUP.
- SETUP: `apb_psel`=1, `apb_enab`=0; `apb_ack` is ignored; always go to ACCESS.
- ACCESS: `apb_psel`=1, `apb_enab`=1. When `apb_ack`=1 on an edge:
  - register `resp_rdata` = `apb_datao` for reads, 0 for writes;
  - set `resp_valid`=1 and `resp_err`=0 for the next cycle;
  - go to IDLE.
- `apb_addr`, `apb_rw`, `apb_datai` are registered and hold their last values in IDLE. They change only on request acceptance.
- `apb_psel` and `apb_enab` are registered decodes of the state. They are never high in IDLE.
- `resp_valid` is high for exactly one cycle per accepted request. There is no response backpressure.
- Only one transfer is outstanding; `req_*` is ignored outside IDLE.

## Timing
- Reset values: `apb_psel`=0, `apb_enab`=0, `apb_rw`=0, `apb_addr`=0, `apb_datai`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, state=IDLE, `req_ready`=1.
- Cycle sequence, request accepted at edge T:
  - cycle T+1: SETUP;
  - cycle T+2: ACCESS;
  - with ack high at T+2, `resp_valid` is high in T+3, and `req_ready` is also high in T+3.
- Zero-wait-state transfer: 3 cycles per transfer. Back-to-back throughput: one transfer per 3 cycles.
- Each wait state (ack low in ACCESS) adds one cycle. `psel`, `enab`, `addr`, `rw`, `datai` stay stable throughout.
- `resp_valid` and a new acceptance may coincide in the same cycle.
- Reset asserted mid-transfer: the next cycle is IDLE with all outputs at reset values, and no response is issued for the aborted transfer.

## Configuration
- Macro `APB_BRIDGE_TIMEOUT_EN`.
- Defined:
  - a counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on entry to ACCESS and increments each ACCESS cycle without ack;
  - if ack is still low when the counter reaches `TIMEOUT_CYCLES`, the bridge goes to IDLE with `resp_valid`=1, `resp_err`=1, `resp_rdata`=0;
  - ack arriving on the expiry edge wins, giving a normal completion with `resp_err`=0.
- Undefined: no counter; ACCESS waits indefinitely; `resp_err` is tied to 0.

## Test plan
- Read 0xBFE8_0004, ack high on the first ACCESS cycle, `apb_datao`=0x1234_5678 → `psel` high 2 cycles, `enab` high 1 cycle, `rw`=0; `resp_valid` 3 cycles after accept with `resp_rdata`=0x1234_5678, `resp_err`=0.
- Write 0xBFE8_0010 with data 0xDEAD_BEEF, ack delayed 4 cycles → `apb_addr` and `apb_datai` stable for 6 cycles; `resp_valid` at accept+7; `resp_rdata`=0.
- Two back-to-back reads with `req_valid` held high → second acceptance in the same cycle as the first `resp_valid`; accepts spaced exactly 3 cycles.
- `rst` asserted during ACCESS → next cycle `psel`=`enab`=0, `req_ready`=1, no `resp_valid` pulse.
- With `APB_BRIDGE_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, ack held low → abort after 8 ACCESS cycles; `resp_err`=1, `resp_rdata`=0; a subsequent normal read completes with `resp_err`=0.
- Request to an unmapped address (mux ack=1, data 0) → completes in 3 cycles with `resp_rdata`=0x0000_0000.
